// File: rtl/data_reg_arbiter.sv
// data_reg_arbiter: round-robin writer of one shared data register, with
// optional bounded lock bursts enabled by the macro DATA_REG_ARB_LOCK_EN.
module data_reg_arbiter #(
    parameter int WORDSIZE = 8,
    parameter int NREQ     = 4,
    parameter int LOCK_MAX = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*WORDSIZE-1:0] wdata,
    input  logic [NREQ-1:0]          lock,
    output logic [NREQ-1:0]          gnt,
    output logic [WORDSIZE-1:0]      data,
    output logic                     data_vld,
    output logic                     locked
);
    localparam int PW = $clog2(NREQ);
    localparam logic [PW:0] NR = (PW+1)'(NREQ);

    logic [PW-1:0]       ptr_q;
    logic [NREQ-1:0]     gnt_q;
    logic [WORDSIZE-1:0] data_q;
    logic                vld_q;
    logic [2*NREQ-1:0]   rot;
    logic [PW-1:0]       off;
    logic [PW:0]         sum;
    logic [PW-1:0]       win;
    logic [PW-1:0]       win_nxt;
    logic                any;
    logic                hold;
    logic                take;
    logic [PW-1:0]       sel;

    // Round-robin winner: rotate req so ptr sits at bit 0, take the lowest set bit.
    always_comb begin
        rot = {req, req} >> ptr_q;
        off = '0;
        for (int i = NREQ - 1; i >= 0; i--)
            if (rot[i]) off = PW'(i);
        sum     = {1'b0, ptr_q} + {1'b0, off};
        win     = (sum >= NR) ? PW'(sum - NR) : PW'(sum);
        win_nxt = (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);
        any     = |req;
    end

`ifdef DATA_REG_ARB_LOCK_EN
    localparam int CW = $clog2(LOCK_MAX + 1);
    typedef enum logic {IDLE, LOCK} state_t;
    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [PW-1:0] owner_q;
    logic          locked_q;

    assign hold   = (state_q == LOCK) && req[owner_q] && lock[owner_q] && (cnt_q < CW'(LOCK_MAX));
    assign sel    = hold ? owner_q : win;
    assign locked = locked_q;

    // Lock FSM: extend the burst while the owner keeps asking, otherwise fall
    // back to idle arbitration, which may immediately start a new burst.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            owner_q  <= '0;
            locked_q <= 1'b0;
        end else if (hold) begin
            cnt_q <= cnt_q + CW'(1);
        end else if (any && lock[win]) begin
            state_q  <= LOCK;
            cnt_q    <= CW'(1);
            owner_q  <= win;
            locked_q <= 1'b1;
        end else begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            locked_q <= 1'b0;
        end
    end
`else
    logic unused_lock;
    assign unused_lock = (^lock) ^ (LOCK_MAX == 0);
    assign hold        = 1'b0;
    assign sel         = win;
    assign locked      = 1'b0;
`endif

    assign take = hold | any;

    // Grant, register load and pointer advance; a locked grant leaves ptr at owner+1.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_q  <= '0;
            data_q <= '0;
            vld_q  <= 1'b0;
            ptr_q  <= '0;
        end else begin
            gnt_q <= take ? (NREQ'(1) << sel) : '0;
            vld_q <= take;
            if (take) data_q <= wdata[sel*WORDSIZE +: WORDSIZE];
            if (!hold && any) ptr_q <= win_nxt;
        end
    end

    assign gnt      = gnt_q;
    assign data     = data_q;
    assign data_vld = vld_q;
endmodule

// File: tb/tb_data_reg_arbiter.sv
// tb_data_reg_arbiter: directed and randomized checks of data_reg_arbiter
// against a spec-level model; lock expectations follow DATA_REG_ARB_LOCK_EN.
module tb_data_reg_arbiter;
    localparam int W  = 8;
    localparam int N  = 4;
    localparam int LM = 3;
`ifdef DATA_REG_ARB_LOCK_EN
    localparam bit LOCK_ON = 1'b1;
`else
    localparam bit LOCK_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [N-1:0] req = '0;
    logic [N-1:0] lock = '0;
    logic [N*W-1:0] wdata = '0;
    logic [N-1:0] gnt;
    logic [W-1:0] data;
    logic data_vld;
    logic locked;

    int checks = 0;
    int passes = 0;

    int m_ptr, m_owner, m_cnt;
    bit m_inlock;
    logic [N-1:0] e_gnt;
    logic [W-1:0] e_data;
    logic e_vld, e_locked;

    data_reg_arbiter #(.WORDSIZE(W), .NREQ(N), .LOCK_MAX(LM)) dut (
        .clk(clk), .rst(rst), .req(req), .wdata(wdata), .lock(lock),
        .gnt(gnt), .data(data), .data_vld(data_vld), .locked(locked)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_ptr = 0; m_owner = 0; m_cnt = 0; m_inlock = 0;
        e_gnt = '0; e_data = '0; e_vld = 1'b0; e_locked = 1'b0;
    endfunction

    function automatic void model_step(logic [N-1:0] r, logic [N-1:0] l, logic [N*W-1:0] wd);
        int w = -1;
        if (m_inlock && r[m_owner] && l[m_owner] && m_cnt < LM) begin
            w = m_owner;
            m_cnt++;
        end else begin
            m_inlock = 0;
            m_cnt = 0;
            for (int k = 0; k < N; k++)
                if (w < 0 && r[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            if (w >= 0) begin
                m_ptr = (w + 1) % N;
                if (LOCK_ON && l[w]) begin
                    m_inlock = 1; m_cnt = 1; m_owner = w;
                end
            end
        end
        e_vld = (w >= 0);
        e_gnt = (w >= 0) ? (N'(1) << w) : '0;
        if (w >= 0) e_data = wd[w*W +: W];
        e_locked = m_inlock;
    endfunction

    task automatic cycle(input logic r_rst, input logic [N-1:0] r, input logic [N-1:0] l, input logic [N*W-1:0] wd);
        rst = r_rst; req = r; lock = l; wdata = wd;
        @(posedge clk);
        #1;
        if (r_rst) model_reset(); else model_step(r, l, wd);
    endtask

    task automatic test_reset();
        cycle(1'b1, 4'b1111, 4'b1111, 32'hDEADBEEF);
        checks++; if (gnt !== 4'b0000) $display("FAIL reset gnt got %b want 0000", gnt); else passes++;
        checks++; if (data !== 8'h00) $display("FAIL reset data got %h want 00", data); else passes++;
        checks++; if (data_vld !== 1'b0) $display("FAIL reset data_vld got %b want 0", data_vld); else passes++;
        checks++; if (locked !== 1'b0) $display("FAIL reset locked got %b want 0", locked); else passes++;
    endtask

    task automatic test_full_contention();
        logic [N-1:0] eg [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [W-1:0] ed [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 4'b1111, 4'b0000, 32'h44332211);
            checks++; if (gnt !== eg[i]) $display("FAIL contention gnt[%0d] got %b want %b", i, gnt, eg[i]); else passes++;
            checks++; if (data !== ed[i]) $display("FAIL contention data[%0d] got %h want %h", i, data, ed[i]); else passes++;
            checks++; if (data_vld !== 1'b1) $display("FAIL contention data_vld[%0d] got %b want 1", i, data_vld); else passes++;
        end
    endtask

    task automatic test_sparse_wrap();
        logic [N-1:0] rq [5] = '{4'b1000, 4'b1001, 4'b1001, 4'b0000, 4'b0000};
        logic [N-1:0] eg [5] = '{4'b1000, 4'b0001, 4'b1000, 4'b0000, 4'b0000};
        logic [W-1:0] ed [5] = '{8'h44, 8'h11, 8'h44, 8'h44, 8'h44};
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, rq[i], 4'b0000, 32'h44332211);
            checks++; if (gnt !== eg[i]) $display("FAIL sparse gnt[%0d] got %b want %b", i, gnt, eg[i]); else passes++;
            checks++; if (data !== ed[i]) $display("FAIL sparse data[%0d] got %h want %h", i, data, ed[i]); else passes++;
            checks++; if (data_vld !== (rq[i] != 0)) $display("FAIL sparse data_vld[%0d] got %b want %b", i, data_vld, rq[i] != 0); else passes++;
        end
    endtask

    task automatic test_lock_forced();
`ifdef DATA_REG_ARB_LOCK_EN
        logic [N-1:0] eg [5] = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0001};
        logic el [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
`else
        logic [N-1:0] eg [5] = '{4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0001};
        logic el [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
        cycle(1'b1, 4'b0000, 4'b0000, 32'h0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 4'b0011, 4'b0001, 32'hD4C3B2A1);
            checks++; if (gnt !== eg[i]) $display("FAIL forced gnt[%0d] got %b want %b", i, gnt, eg[i]); else passes++;
            checks++; if (locked !== el[i]) $display("FAIL forced locked[%0d] got %b want %b", i, locked, el[i]); else passes++;
            checks++; if (data !== e_data) $display("FAIL forced data[%0d] got %h want %h", i, data, e_data); else passes++;
        end
    endtask

    task automatic test_voluntary_exit();
        logic [N-1:0] lk [4] = '{4'b0001, 4'b0001, 4'b0000, 4'b0000};
`ifdef DATA_REG_ARB_LOCK_EN
        logic [N-1:0] eg [4] = '{4'b0001, 4'b0001, 4'b0010, 4'b0001};
        logic el [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
`else
        logic [N-1:0] eg [4] = '{4'b0001, 4'b0010, 4'b0001, 4'b0010};
        logic el [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        cycle(1'b1, 4'b0000, 4'b0000, 32'h0);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 4'b0011, lk[i], 32'h44332211);
            checks++; if (gnt !== eg[i]) $display("FAIL volexit gnt[%0d] got %b want %b", i, gnt, eg[i]); else passes++;
            checks++; if (locked !== el[i]) $display("FAIL volexit locked[%0d] got %b want %b", i, locked, el[i]); else passes++;
            checks++; if (data_vld !== 1'b1) $display("FAIL volexit data_vld[%0d] got %b want 1", i, data_vld); else passes++;
        end
    endtask

    task automatic test_reset_mid_burst();
        cycle(1'b1, 4'b0000, 4'b0000, 32'h0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 4'b0010, 4'b0010, 32'h44332211);
            checks++; if (gnt !== 4'b0010) $display("FAIL midburst gnt[%0d] got %b want 0010", i, gnt); else passes++;
            checks++; if (locked !== LOCK_ON) $display("FAIL midburst locked[%0d] got %b want %b", i, locked, LOCK_ON); else passes++;
        end
        cycle(1'b1, 4'b0010, 4'b0010, 32'h44332211);
        checks++; if (gnt !== 4'b0000) $display("FAIL midburst rst gnt got %b want 0000", gnt); else passes++;
        checks++; if (data !== 8'h00) $display("FAIL midburst rst data got %h want 00", data); else passes++;
        checks++; if (data_vld !== 1'b0) $display("FAIL midburst rst data_vld got %b want 0", data_vld); else passes++;
        checks++; if (locked !== 1'b0) $display("FAIL midburst rst locked got %b want 0", locked); else passes++;
        cycle(1'b0, 4'b0010, 4'b0010, 32'h44332211);
        checks++; if (gnt !== 4'b0010) $display("FAIL midburst after gnt got %b want 0010", gnt); else passes++;
        checks++; if (data !== 8'h22) $display("FAIL midburst after data got %h want 22", data); else passes++;
        checks++; if (locked !== LOCK_ON) $display("FAIL midburst after locked got %b want %b", locked, LOCK_ON); else passes++;
    endtask

    task automatic test_random();
        logic [N-1:0] r, l;
        logic [N*W-1:0] wd;
        logic rr;
        for (int i = 0; i < 400; i++) begin
            r  = N'($urandom_range(0, 15));
            l  = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom_range(0, 15));
            wd = $urandom;
            rr = ($urandom_range(0, 63) == 0);
            cycle(rr, r, l, wd);
            checks++; if (gnt !== e_gnt) $display("FAIL random gnt[%0d] got %b want %b", i, gnt, e_gnt); else passes++;
            checks++; if (data !== e_data) $display("FAIL random data[%0d] got %h want %h", i, data, e_data); else passes++;
            checks++; if (data_vld !== e_vld) $display("FAIL random data_vld[%0d] got %b want %b", i, data_vld, e_vld); else passes++;
            checks++; if (locked !== e_locked) $display("FAIL random locked[%0d] got %b want %b", i, locked, e_locked); else passes++;
            checks++; if ($countones(gnt) > 1 || (|gnt) !== data_vld) $display("FAIL random onehot[%0d] got gnt %b vld %b want onehot matching vld", i, gnt, data_vld); else passes++;
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_full_contention();
        test_sparse_wrap();
        test_lock_forced();
        test_voluntary_exit();
        test_reset_mid_burst();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/data_reg_arbiter.md
# data_reg_arbiter

Round-robin arbiter that shares one `WORDSIZE`-bit data register between `NREQ` requesters. Each cycle it picks at most one requester, loads that requester's write word into the shared register and returns a one-cycle grant. It sits between the requester-side logic and the register consumer, and is the only writer of the register. Optionally, a requester can hold the register for a bounded burst of consecutive writes.

## Interface
Parameters:
- `WORDSIZE`, default 8: width of the shared data register.
- `NREQ`, default 4: number of requesters, 2..8.
- `LOCK_MAX`, default 15: maximum number of consecutive grants in one locked burst. Only used when locking is compiled in.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req`  in  NREQ  per-requester write request, level.
- `wdata`  in  NREQ*WORDSIZE  write words; requester i is at bits [i*WORDSIZE +: WORDSIZE].
- `lock`  in  NREQ  per-requester burst-hold request; ignored when locking is compiled out.
- `gnt`  out  NREQ  one-hot registered grant; pulses 1 cycle per accepted write.
- `data`  out  WORDSIZE  shared register contents.
- `data_vld`  out  1  high for the 1 cycle after `data` was loaded.
- `locked`  out  1  high while a locked burst owns the register.

## Operation
Reset applies on a rising edge with `rst`=1:
- `gnt`=0, `data`=0, `data_vld`=0, `locked`=0.
- Priority pointer `ptr`=0, burst counter `cnt`=0, state `IDLE`.
- `rst` overrides every other input. A burst in progress is abandoned, and no grant follows in the reset cycle.

State machine has two states, `IDLE` and `LOCK`.

In `IDLE`:
- If `req`=0, then `gnt` is 0 and `data_vld` is 0 on the next cycle. `data` holds its value.
- Otherwise, winner W is the first set bit of `req`, searching upward from `ptr` and wrapping from NREQ-1 to 0.
- On the edge:
  - `gnt` ← onehot(W)
  - `data` ← `wdata`[W]
  - `data_vld` ← 1
  - `ptr` ← (W+1) mod NREQ
- If locking is enabled and `lock`[W]=1 on that edge, the state goes to `LOCK`, with `locked` ← 1, `cnt` ← 1 and owner ← W.

In `LOCK` (owner O):
- If `req`[O]=1, `lock`[O]=1 and `cnt`<`LOCK_MAX`, the register is granted to O again: `gnt`, `data` and `data_vld` update as in `IDLE`, and `cnt` increments. `ptr` stays at O+1.
- Otherwise, the same edge leaves `LOCK`: `locked` ← 0, `cnt` ← 0, state ← `IDLE`.
- That exit edge also performs a normal `IDLE` arbitration from `ptr`=O+1, so no cycle is lost.
- The `cnt`=`LOCK_MAX` release is forced. O is skipped only because of the pointer; it may re-lock on its next round-robin turn.

Other rules:
- Requesters not granted keep `req` asserted. The arbiter has no queue.
- A request dropped before being granted is simply not served.
- `data` changes only on a grant edge.
- `req` and `lock` changing in the same cycle follow the rules above with no special priority.

## Timing
- Latency is 1 cycle: a `req` sampled at edge N produces `gnt`, `data` and `data_vld` valid after edge N.
- Throughput is 1 grant per cycle when any request is pending, including across lock entry and exit.
- Fairness without lock: with all requesters continuously active, each requester gets exactly 1 grant every NREQ cycles.
- Fairness with lock: the worst-case wait is (NREQ-1)·`LOCK_MAX` grants.
- `gnt` and `data_vld` are always asserted together. `gnt` is never more than one-hot.

## Configuration
- Macro `DATA_REG_ARB_LOCK_EN`.
- Defined: the `LOCK` state, `cnt`, `LOCK_MAX` and the `lock` input are active as described above.
- Undefined: the arbiter stays in `IDLE`, the `lock` input is ignored and `locked` is tied to 0. It behaves as a pure round-robin arbiter.

## Test plan
- **Reset mid-burst.** With the macro on, hold `req`=4'b0010 and `lock`=4'b0010 for 3 cycles, then assert `rst` for 1 cycle. Required next cycle: `gnt`=0, `data`=0, `data_vld`=0, `locked`=0. After `rst` falls with the same inputs, the next grant is 4'b0010 with `ptr` arbitration starting from 0.
- **Full contention.** NREQ=4, `req`=4'b1111 held, `wdata`={8'h44,8'h33,8'h22,8'h11}. Required `gnt` sequence: 0001, 0010, 0100, 1000, 0001. Required `data` sequence: 11, 22, 33, 44, 11. `data_vld` stays high throughout.
- **Sparse requests and wrap.** `req`=4'b1001 held after a grant to requester 3. Required next grant is 0001 (wrap to 0), then 1000. With `req`=0, `gnt` stays 0 and `data` holds its last value.
- **Lock burst with forced release.** Macro on, `LOCK_MAX`=3, `req`=4'b0011, `lock`=4'b0001, `ptr`=0. Required grants: 0001 three times with `locked`=1, then 0010 with `locked`=0, then 0001 again.
- **Voluntary lock exit.** Macro on, drop `lock`[0] after 2 locked grants. On the next edge `locked`=0 and the grant goes to the next pending requester, with no idle cycle.
- **Macro off.** Same stimulus as the forced-release test. Required grants alternate 0001, 0010, and `locked` stays 0.
